// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter (fetch/data) for a single-ported sync memory; define MEM_ARB_FAIR_EN for the fetch-starvation guard
module mem_port_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_D_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_wmask,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {NONE, OWN_IF, OWN_D} owner_t;
   owner_t owner, owner_nx;
   logic [ADDR_W-1:0] addr_q;
   logic fetch_pri;
`ifdef MEM_ARB_FAIR_EN
   localparam int RUN_W = $clog2(MAX_D_RUN + 1);
   logic [RUN_W-1:0] run, run_nx;
   assign fetch_pri = if_req && run == RUN_W'(MAX_D_RUN);
   // count data grants taken while fetch waits, saturating at the limit
   always_comb run_nx = (if_gnt || !if_req) ? '0 : (d_gnt && run != RUN_W'(MAX_D_RUN)) ? run + 1'b1 : run;
   // run counter register
   always_ff @(posedge clk) run <= rst ? '0 : run_nx;
`else
   assign fetch_pri = 1'b0;
`endif
   assign d_gnt     = !rst && d_req && !fetch_pri;
   assign if_gnt    = !rst && if_req && !d_gnt;
   assign if_stall  = if_req && !if_gnt;
   assign d_stall   = d_req && !d_gnt;
   assign mem_we    = (d_gnt && d_we) ? d_wmask : 4'b0000;
   assign mem_wdata = d_wdata;
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;
   // address follows the granted requester, otherwise holds the last driven value
   always_comb mem_addr = if_gnt ? if_addr : d_gnt ? d_addr : addr_q;
   // owner state register and held address
   always_ff @(posedge clk) begin
      owner  <= rst ? NONE : owner_nx;
      addr_q <= rst ? '0 : mem_addr;
   end
   // next owner is whoever is granted this cycle
   always_comb owner_nx = if_gnt ? OWN_IF : d_gnt ? OWN_D : NONE;
   // response valids; reset drops any in-flight response
   always_comb begin
      if_valid = !rst && owner == OWN_IF;
      d_valid  = !rst && owner == OWN_D;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed checks of mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
   localparam int AW = 12, DW = 32, MAXR = 4;
`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 0, d_req = 0, d_we = 0;
   logic [AW-1:0] if_addr = 0, d_addr = 0;
   logic [3:0] d_wmask = 0;
   logic [DW-1:0] d_wdata = 0;
   logic if_gnt, if_valid, if_stall, d_gnt, d_valid, d_stall;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [3:0] mem_we;
   int n_chk = 0, n_fail = 0;
   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] ref_mem [1<<AW];
   int run = 0, owner = 0;
   logic [AW-1:0] last_addr = 0;
   logic [DW-1:0] exp_rdata = 0;
   string gseq;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                        input logic [3:0] dm, input logic [AW-1:0] da, input logic [DW-1:0] dw);
      logic e_d, e_i, e_iv, e_dv;
      logic [AW-1:0] e_addr;
      logic [3:0] e_we;
      @(posedge clk);
      #1;
      rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_wmask = dm; d_addr = da; d_wdata = dw;
      e_d = !r && dr && !(FAIR && ir && run >= MAXR);
      e_i = !r && ir && !e_d;
      e_addr = e_i ? ia : e_d ? da : last_addr;
      e_we = (e_d && dwe) ? dm : 4'b0;
      e_iv = !r && owner == 1;
      e_dv = !r && owner == 2;
      #4;
      chk("if_gnt", if_gnt, e_i);
      chk("d_gnt", d_gnt, e_d);
      chk("if_stall", if_stall, ir && !e_i);
      chk("d_stall", d_stall, dr && !e_d);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_wdata", mem_wdata, dw);
      chk("if_valid", if_valid, e_iv);
      chk("d_valid", d_valid, e_dv);
      if (e_iv) chk("if_rdata", if_rdata, exp_rdata);
      if (e_dv) chk("d_rdata", d_rdata, exp_rdata);
      gseq = {gseq, e_i ? "I" : e_d ? "D" : "-"};
      if (r) begin
         owner = 0; run = 0; last_addr = 0;
      end else begin
         owner = e_i ? 1 : e_d ? 2 : 0;
         last_addr = e_addr;
         if (e_i || !ir) run = 0;
         else if (e_d && run < MAXR) run++;
      end
      exp_rdata = ref_mem[e_addr];
      for (int b = 0; b < 4; b++) if (e_we[b]) ref_mem[e_addr][8*b +: 8] = dw[8*b +: 8];
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      repeat (2) @(posedge clk);
      cycle(1, 1, 12'h111, 1, 1, 4'hF, 12'h222, 32'h1);
      idle();
      cycle(0, 1, 12'h010, 0, 0, 0, 0, 0);
      idle();
      cycle(0, 1, 12'h020, 1, 0, 0, 12'h300, 32'h5);
      idle();
      idle();
      cycle(0, 0, 0, 1, 1, 4'b0011, 12'h040, 32'hDEADBEEF);
      idle();
      cycle(0, 0, 0, 1, 0, 0, 12'h040, 0);
      #1;
      chk("store_halfword", d_rdata[15:0], 16'hBEEF);
      idle();
      gseq = "";
      for (int i = 0; i < 10; i++) cycle(0, 1, 12'h050, 1, 0, 0, 12'h060, 0);
      chk("starve_seq", (gseq == (FAIR ? "DDDDIDDDDI" : "DDDDDDDDDD")), 1'b1);
      idle();
      cycle(0, 0, 0, 1, 0, 0, 12'h070, 0);
      cycle(1, 1, 12'h071, 1, 1, 4'hF, 12'h072, 32'h9);
      idle();
      idle();
      for (int i = 0; i < 5; i++) cycle(0, 1, AW'(i), 0, 0, 0, 0, 0);
      idle();
      idle();
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 4'($urandom), AW'($urandom_range(0, 63)), $urandom);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
